// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline stage registers.
// Holds the control-bit positions inside the control bundle, the default
// bundle widths and the occupancy encoding reported by each stage.
package pipe_pkg;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 128;

  // Bit positions inside the control bundle
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMREAD   = 2;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_ALUOP_LSB = 6;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry: valid bit plus control and data bundles.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (clears valid, ctrl, data)
//   load_i         capture ctrl_i/data_i and mark the entry valid
//   clr_i          drop the entry (valid cleared, data held); wins over load_i
//   ctrl_i/data_i  incoming bundles
//   vld_o          entry valid
//   ctrl_o         control bundle, forced to zero while the entry is invalid
//   data_o         data bundle as last loaded
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage p0: entry register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
      data_p0 <= '0;
    end else if (clr_i) begin
      vld_p0 <= 1'b0;
    end else if (load_i) begin
      vld_p0  <= 1'b1;
      ctrl_p0 <= ctrl_i;
      data_p0 <= data_i;
    end
  end

  assign vld_o  = vld_p0;
  // A bubble must never carry live control bits downstream.
  assign ctrl_o = vld_p0 ? ctrl_p0 : '0;
  assign data_o = data_p0;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating flush-drop counter.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   in_valid_i/in_ready_o              upstream handshake
//   in_ctrl_i/in_data_i                upstream bundles
//   out_valid_o/out_ready_i            downstream handshake
//   out_ctrl_o/out_data_o              downstream bundles (ctrl zero when idle)
//   flush_i                            discard everything held and incoming
//   occ_o                              occupancy 0..2
//   drop_cnt_o                         saturating count of flushed entries
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    if (s[CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic              in_xfer, out_xfer;
  logic              main_vld, skid_vld;
  logic              main_load, main_clr;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  logic [1:0]        drop_n;
  logic [CNT_W-1:0]  drop_cnt_p0;
  occ_e              occ;

  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = main_vld & out_ready_i;
  assign out_valid_o = main_vld;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (main_load),
    .clr_i  (main_clr),
    .ctrl_i (main_ctrl_d),
    .data_i (main_data_d),
    .vld_o  (main_vld),
    .ctrl_o (out_ctrl_o),
    .data_o (out_data_o)
  );

  if (SKID) begin : g_skid
    logic              skid_load, skid_clr, from_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    always_comb begin
      main_load = 1'b0;
      main_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      from_skid = 1'b0;
      if (flush_i) begin
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end else if (!main_vld) begin
        main_load = in_xfer;
      end else if (out_xfer) begin
        if (skid_vld) begin
          // Oldest waiting entry moves up; input is blocked while skid is full.
          main_load = 1'b1;
          from_skid = 1'b1;
          skid_clr  = 1'b1;
        end else if (in_xfer) begin
          main_load = 1'b1;
        end else begin
          main_clr = 1'b1;
        end
      end else begin
        skid_load = in_xfer;
      end
    end

    assign main_ctrl_d = from_skid ? skid_ctrl : in_ctrl_i;
    assign main_data_d = from_skid ? skid_data : in_data_i;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (skid_load),
      .clr_i  (skid_clr),
      .ctrl_i (in_ctrl_i),
      .data_i (in_data_i),
      .vld_o  (skid_vld),
      .ctrl_o (skid_ctrl),
      .data_o (skid_data)
    );

    // Ready depends only on flop state, so it breaks the ready timing path.
    assign in_ready_o = ~skid_vld;
  end else begin : g_noskid
    assign skid_vld    = 1'b0;
    assign in_ready_o  = ~main_vld | out_ready_i;
    assign main_ctrl_d = in_ctrl_i;
    assign main_data_d = in_data_i;

    always_comb begin
      main_load = in_xfer & ~flush_i;
      main_clr  = flush_i | (out_xfer & ~in_xfer);
    end
  end

  always_comb begin
    case ({skid_vld, main_vld})
      2'b01:   occ = OCC_ONE;
      2'b11:   occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
  end
  assign occ_o = occ;

  // An entry leaving through the output port in the flush cycle is delivered,
  // not dropped.
  assign drop_n = {1'b0, main_vld & ~out_ready_i} + {1'b0, skid_vld} + {1'b0, in_xfer};

  // Stage p0: flush-drop counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_p0 <= '0;
    end else if (flush_i) begin
      drop_cnt_p0 <= sat_add(drop_cnt_p0, drop_n);
    end
  end
  assign drop_cnt_o = drop_cnt_p0;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register for the in-order pipeline, usable between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle under a valid/ready handshake.
- Supports back-pressure through an optional 2-entry skid buffer and a synchronous flush that inserts bubbles.
- Control bits are forced to zero whenever the stage holds no valid entry, so a bubble never writes registers or memory.

Parameters:
- CTRL_W, 8, width of control bundle (ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg, Branch, spare).
- DATA_W, 128, width of data bundle (rs1/rs2 data, imm, funct, rs/rt/rd addresses, packed by the instantiating stage).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with combinational in_ready_o.
- CNT_W, 8, width of the saturating flush-drop counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  upstream entry valid.
- in_ready_o  output  1  stage can accept an entry this cycle.
- in_ctrl_i  input  CTRL_W  upstream control bundle.
- in_data_i  input  DATA_W  upstream data bundle.
- out_valid_o  output  1  stage presents a valid entry.
- out_ready_i  input  1  downstream accepts the entry this cycle.
- out_ctrl_o  output  CTRL_W  control bundle; all-zero when out_valid_o=0.
- out_data_o  output  DATA_W  data bundle; don't-care when out_valid_o=0.
- flush_i  input  1  synchronous flush (branch taken or hazard bubble).
- occ_o  output  2  current occupancy, 0..2 (max 1 when SKID=0).
- drop_cnt_o  output  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Reset (async, rst_i=1):
  - out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0, drop_cnt_o=0.
  - Skid entry invalid and zeroed.
  - in_ready_o=1 while rst_i is high and in the first cycle after release.
- Transfers:
  - Input transfer occurs when in_valid_i & in_ready_o at a rising edge.
  - Output transfer occurs when out_valid_o & out_ready_i at a rising edge.
- Latency: 1 cycle. An entry accepted at edge N appears on out_* after edge N, provided the main register is empty or draining.
- Ordering: strict FIFO. Entries are never duplicated or reordered.
- SKID=1 states: EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
  - EMPTY + in xfer -> ONE.
  - ONE + in xfer, no out xfer -> TWO; the incoming entry goes to the skid register.
  - ONE + in xfer + out xfer -> ONE; main register loads the new entry.
  - ONE + out xfer only -> EMPTY.
  - TWO + out xfer -> ONE; main register loads from the skid register.
  - in_ready_o = registered !(skid valid). In TWO, in_ready_o=0, so no input transfer is possible.
- SKID=0:
  - in_ready_o = !out_valid_o | out_ready_i (combinational from out_ready_i).
  - occ_o is 0 or 1.
- Flush (sync, highest priority below reset):
  - At the edge, all held entries and any input transferred in the same cycle are discarded.
  - After the edge: out_valid_o=0, out_ctrl_o=0, occ_o=0, in_ready_o=1.
  - out_data_o holds its last value.
  - drop_cnt_o += (valid entries held) + (1 if in xfer that cycle), saturating at 2^CNT_W-1.
  - An output transfer in the flush cycle is not counted as dropped.
- Simultaneous flush and reset: reset wins.
- Reset mid-operation: all entries lost immediately (async); drop_cnt_o is cleared and not incremented.
- Control gating: out_ctrl_o is always 0 whenever out_valid_o=0, including after drain and after flush.
- Stall by back-pressure (out_ready_i=0): out_* hold stable while out_valid_o=1.
- Widths: all bundles pass through unchanged. The counter saturates and never wraps.

Decomposition:
- Shared package pipe_pkg holds:
  - Control-bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_ALUSRC=4, CTRL_BRANCH=5, CTRL_ALUOP_LSB=6).
  - Default CTRL_W/DATA_W.
  - The occupancy encoding constants OCC_EMPTY/ONE/TWO.
- One sub-module is natural: pipe_entry_reg, a single valid+ctrl+data register with load/clear/zero-ctrl behaviour. It is instantiated twice (main, skid) when SKID=1.

Test Plan:
- Streaming: SKID=1, out_ready_i=1, feed ctrl 0x01..0x05 on consecutive cycles -> same sequence on out_ctrl_o one cycle later; occ_o=1 throughout; in_ready_o stays 1.
- Back-pressure: hold out_ready_i=0 and send ctrl 0x11, 0x22 -> occ_o=2, in_ready_o=0, out_ctrl_o stable at 0x11. Release -> 0x11 then 0x22 in order, then occ_o=0 and out_ctrl_o=0.
- Flush while full: occ_o=2 with in_valid_i=1 and flush_i=1 -> next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0, drop_cnt_o=2 (input rejected since in_ready_o=0).
- Flush with input: occ_o=1, out_ready_i=0, in xfer ctrl 0x7F with flush_i=1 -> drop_cnt_o +=2, no entry emerges.
- Saturation: CNT_W=2, apply 3 flushes each dropping 2 entries -> drop_cnt_o=3 and stays 3.
- Async reset mid-stream: assert rst_i between edges with occ_o=2 -> out_valid_o=0 and out_ctrl_o=0 immediately, drop_cnt_o=0. SKID=0 variant: out_ready_i toggling 1/0 -> in_ready_o follows combinationally.
